addsub_seq: RTL and testbench

- Sequential front end for the 8-bit add/subtract datapath.
- Accepts an operand pair and an operation code over a valid/ready handshake, and registers the operands.
- Computes a two's-complement sum, difference or running accumulation with a signed-overflow flag.
- Holds the registered result until a downstream consumer accepts it. Also maintains a sticky overflow flag for software polling.

---
 rtl/addsub_seq_if.sv | 27 ++
 rtl/addsub_seq.sv | 126 ++++++++++++
 tb/tb_addsub_seq.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/addsub_seq_if.sv
// Request/response bundle for addsub_seq: operand request channel in,
// registered result channel out, both valid/ready.
interface addsub_seq_if #(
    parameter int unsigned WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [1:0]       op_sel;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             of_flag;

    // Upstream producer / downstream consumer side.
    modport master (
        output in_valid, op_a, op_b, op_sel, out_ready,
        input  in_ready, out_valid, result, of_flag
    );

    // Block side.
    modport slave (
        input  in_valid, op_a, op_b, op_sel, out_ready,
        output in_ready, out_valid, result, of_flag
    );
endinterface

// File: rtl/addsub_seq.sv
// Sequential add/subtract/accumulate front end. Three-state FSM:
// IDLE captures a request, EXEC computes and registers the result,
// HOLD presents it until the consumer accepts. Sticky overflow for polling.
module addsub_seq #(
    parameter int unsigned WIDTH = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    addsub_seq_if.slave    bus,
    input  logic           clear_sticky,
    output logic           sticky_of
);
    localparam int unsigned Msb = WIDTH - 1;

    localparam logic [1:0] OpAdd = 2'b00;
    localparam logic [1:0] OpSub = 2'b01;
    localparam logic [1:0] OpAcc = 2'b10;
    localparam logic [1:0] OpClr = 2'b11;

    typedef enum logic [1:0] {StIdle, StExec, StHold} state_e;

    state_e           state_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [1:0]       sel_q;
    logic [WIDTH-1:0] acc_q;
    logic             in_ready_q;
    logic             out_valid_q;
    logic [WIDTH-1:0] result_q;
    logic             of_q;
    logic             sticky_q;

    logic [WIDTH-1:0] calc_r;
    logic             calc_of;

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.result    = result_q;
    assign bus.of_flag   = of_q;
    assign sticky_of     = sticky_q;

    // Datapath: result and signed overflow from the captured operands.
    always_comb begin
        calc_r  = '0;
        calc_of = 1'b0;
        unique case (sel_q)
            OpAdd: begin
                calc_r  = a_q + b_q;
                calc_of = (a_q[Msb] == b_q[Msb]) && (calc_r[Msb] != a_q[Msb]);
            end
            OpSub: begin
                // Invert-and-increment keeps the overflow rule valid for b = most-negative.
                calc_r  = a_q + ~b_q + WIDTH'(1);
                calc_of = (a_q[Msb] != b_q[Msb]) && (calc_r[Msb] != a_q[Msb]);
            end
            OpAcc: begin
                calc_r  = acc_q + a_q;
                calc_of = (acc_q[Msb] == a_q[Msb]) && (calc_r[Msb] != acc_q[Msb]);
            end
            OpClr: begin
                calc_r  = '0;
                calc_of = 1'b0;
            end
            default: begin
                calc_r  = '0;
                calc_of = 1'b0;
            end
        endcase
    end

    // Control FSM with registered handshake outputs, accumulator and sticky flag.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            a_q         <= '0;
            b_q         <= '0;
            sel_q       <= OpAdd;
            acc_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            of_q        <= 1'b0;
            sticky_q    <= 1'b0;
        end else begin
            if (clear_sticky) begin
                sticky_q <= 1'b0;
            end
            case (state_q)
                StIdle: begin
                    if (bus.in_valid) begin
                        a_q        <= bus.op_a;
                        b_q        <= bus.op_b;
                        sel_q      <= bus.op_sel;
                        in_ready_q <= 1'b0;
                        state_q    <= StExec;
                    end
                end
                StExec: begin
                    result_q    <= calc_r;
                    of_q        <= calc_of;
                    out_valid_q <= 1'b1;
                    // Later assignment overrides a same-cycle clear_sticky.
                    if (calc_of) begin
                        sticky_q <= 1'b1;
                    end
                    if ((sel_q == OpAcc) || (sel_q == OpClr)) begin
                        acc_q <= calc_r;
                    end
                    state_q <= StHold;
                end
                StHold: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= StIdle;
                    end
                end
                default: begin
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                    state_q     <= StIdle;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_addsub_seq.sv
// Directed bench for addsub_seq: reset, add/sub overflow, backpressure,
// accumulator, mid-operation reset and sticky clear race.
module tb_addsub_seq;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic clear_sticky = 1'b0;
    logic sticky_of;
    int   checks = 0;
    int   errors = 0;

    addsub_seq_if #(.WIDTH(8)) bus ();

    addsub_seq #(.WIDTH(8)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .bus          (bus),
        .clear_sticky (clear_sticky),
        .sticky_of    (sticky_of)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one request with out_ready=1 and return what the output presented.
    task automatic run_op(input logic [1:0] sel, input logic [7:0] a, input logic [7:0] b,
                          output logic [7:0] r, output logic f, output logic s);
        int n;
        bus.op_sel    = sel;
        bus.op_a      = a;
        bus.op_b      = b;
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        n = 0;
        while (bus.in_ready !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        tick();
        bus.in_valid = 1'b0;
        bus.op_a     = 8'hA5;
        bus.op_b     = 8'h5A;
        bus.op_sel   = ~sel;
        while (bus.out_valid !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        checks++;
        if (bus.out_valid !== 1'b1) begin
            errors++;
            $display("FAIL op_timeout: out_valid=%b, required 1 within budget", bus.out_valid);
        end
        r = bus.result;
        f = bus.of_flag;
        s = sticky_of;
        tick();
    endtask

    task automatic test_reset();
        logic [7:0] r;
        logic f, s;
        rst_n = 1'b0;
        tick();
        tick();
        checks++; if (bus.in_ready !== 1'b1) begin errors++;
            $display("FAIL reset_in_ready: got %b required 1", bus.in_ready); end
        checks++; if (bus.out_valid !== 1'b0) begin errors++;
            $display("FAIL reset_out_valid: got %b required 0", bus.out_valid); end
        checks++; if (bus.result !== 8'h00) begin errors++;
            $display("FAIL reset_result: got %h required 00", bus.result); end
        checks++; if (bus.of_flag !== 1'b0) begin errors++;
            $display("FAIL reset_of_flag: got %b required 0", bus.of_flag); end
        checks++; if (sticky_of !== 1'b0) begin errors++;
            $display("FAIL reset_sticky: got %b required 0", sticky_of); end
        rst_n = 1'b1;
        tick();
        run_op(2'b10, 8'h05, 8'h00, r, f, s);
        checks++; if (r !== 8'h05 || f !== 1'b0) begin errors++;
            $display("FAIL reset_acc: got %h/%b required 05/0", r, f); end
    endtask

    task automatic test_add();
        logic [7:0] r;
        logic f, s;
        bus.op_sel    = 2'b00;
        bus.op_a      = 8'h7F;
        bus.op_b      = 8'h01;
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        tick();
        checks++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b0) begin errors++;
            $display("FAIL add_latency1: out_valid/in_ready %b/%b required 0/0",
                     bus.out_valid, bus.in_ready); end
        bus.in_valid = 1'b0;
        bus.op_a     = 8'h00;
        tick();
        checks++; if (bus.out_valid !== 1'b1) begin errors++;
            $display("FAIL add_latency2: out_valid %b required 1", bus.out_valid); end
        checks++; if (bus.result !== 8'h80 || bus.of_flag !== 1'b1) begin errors++;
            $display("FAIL add_7f_01: got %h/%b required 80/1", bus.result, bus.of_flag); end
        checks++; if (sticky_of !== 1'b1) begin errors++;
            $display("FAIL add_sticky_set: got %b required 1", sticky_of); end
        tick();
        checks++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin errors++;
            $display("FAIL add_handshake: out_valid/in_ready %b/%b required 0/1",
                     bus.out_valid, bus.in_ready); end
        run_op(2'b00, 8'h05, 8'h03, r, f, s);
        checks++; if (r !== 8'h08 || f !== 1'b0 || s !== 1'b1) begin errors++;
            $display("FAIL add_05_03: got %h/%b sticky %b required 08/0 sticky 1", r, f, s); end
    endtask

    task automatic test_sub();
        logic [7:0] va[4] = '{8'h80, 8'h00, 8'h05, 8'hFF};
        logic [7:0] vb[4] = '{8'h01, 8'h80, 8'h03, 8'hFF};
        logic [7:0] vr[4] = '{8'h7F, 8'h80, 8'h02, 8'h00};
        logic       vf[4] = '{1'b1, 1'b1, 1'b0, 1'b0};
        logic [7:0] r;
        logic f, s;
        for (int i = 0; i < 4; i++) begin
            run_op(2'b01, va[i], vb[i], r, f, s);
            checks++; if (r !== vr[i] || f !== vf[i]) begin errors++;
                $display("FAIL sub_%0d: %h-%h got %h/%b required %h/%b",
                         i, va[i], vb[i], r, f, vr[i], vf[i]); end
        end
    endtask

    task automatic test_backpressure();
        int n;
        bus.out_ready = 1'b0;
        bus.op_sel    = 2'b00;
        bus.op_a      = 8'h10;
        bus.op_b      = 8'h20;
        bus.in_valid  = 1'b1;
        tick();
        // Second request held from here; must wait for the first to drain.
        bus.op_a = 8'h01;
        bus.op_b = 8'h01;
        n = 0;
        while (bus.out_valid !== 1'b1 && n < 10) begin
            tick();
            n++;
        end
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 ||
                bus.result !== 8'h30 || bus.of_flag !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold_%0d: valid/ready/result/of %b/%b/%h/%b required 1/0/30/0",
                         i, bus.out_valid, bus.in_ready, bus.result, bus.of_flag);
            end
            tick();
        end
        bus.out_ready = 1'b1;
        tick();
        checks++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin errors++;
            $display("FAIL bp_release: valid/ready %b/%b required 0/1",
                     bus.out_valid, bus.in_ready); end
        tick();
        checks++; if (bus.in_ready !== 1'b0) begin errors++;
            $display("FAIL bp_next_accept: in_ready %b required 0", bus.in_ready); end
        bus.in_valid = 1'b0;
        tick();
        checks++; if (bus.out_valid !== 1'b1 || bus.result !== 8'h02) begin errors++;
            $display("FAIL bp_second: valid/result %b/%h required 1/02",
                     bus.out_valid, bus.result); end
        tick();
    endtask

    task automatic test_accumulate();
        logic [1:0] vs[6] = '{2'b11, 2'b10, 2'b10, 2'b10, 2'b00, 2'b10};
        logic [7:0] va[6] = '{8'h00, 8'h40, 8'h30, 8'h20, 8'h01, 8'h00};
        logic [7:0] vb[6] = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h01, 8'h00};
        logic [7:0] vr[6] = '{8'h00, 8'h40, 8'h70, 8'h90, 8'h02, 8'h90};
        logic       vf[6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        logic [7:0] r;
        logic f, s;
        for (int i = 0; i < 6; i++) begin
            run_op(vs[i], va[i], vb[i], r, f, s);
            checks++; if (r !== vr[i] || f !== vf[i]) begin errors++;
                $display("FAIL acc_%0d: op %0d a %h got %h/%b required %h/%b",
                         i, vs[i], va[i], r, f, vr[i], vf[i]); end
        end
    endtask

    task automatic test_reset_mid();
        logic [7:0] r;
        logic f, s;
        bus.op_sel    = 2'b10;
        bus.op_a      = 8'h11;
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        rst_n        = 1'b0;
        tick();
        checks++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin errors++;
            $display("FAIL midrst_state: valid/ready %b/%b required 0/1",
                     bus.out_valid, bus.in_ready); end
        checks++; if (bus.result !== 8'h00 || sticky_of !== 1'b0) begin errors++;
            $display("FAIL midrst_regs: result/sticky %h/%b required 00/0",
                     bus.result, sticky_of); end
        rst_n = 1'b1;
        tick();
        tick();
        checks++; if (bus.out_valid !== 1'b0) begin errors++;
            $display("FAIL midrst_no_output: out_valid %b required 0", bus.out_valid); end
        run_op(2'b10, 8'h03, 8'h00, r, f, s);
        checks++; if (r !== 8'h03 || f !== 1'b0) begin errors++;
            $display("FAIL midrst_acc_cleared: got %h/%b required 03/0", r, f); end
    endtask

    task automatic test_clear_race();
        bus.op_sel    = 2'b00;
        bus.op_a      = 8'h7F;
        bus.op_b      = 8'h01;
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b0;
        tick();
        bus.in_valid = 1'b0;
        clear_sticky = 1'b1;
        tick();
        checks++; if (sticky_of !== 1'b1 || bus.of_flag !== 1'b1) begin errors++;
            $display("FAIL race_set_wins: sticky/of %b/%b required 1/1", sticky_of, bus.of_flag); end
        tick();
        checks++; if (sticky_of !== 1'b0 || bus.out_valid !== 1'b1) begin errors++;
            $display("FAIL race_clear: sticky/out_valid %b/%b required 0/1",
                     sticky_of, bus.out_valid); end
        clear_sticky  = 1'b0;
        bus.out_ready = 1'b1;
        tick();
        checks++; if (bus.out_valid !== 1'b0) begin errors++;
            $display("FAIL race_drain: out_valid %b required 0", bus.out_valid); end
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.op_a      = 8'h00;
        bus.op_b      = 8'h00;
        bus.op_sel    = 2'b00;
        test_reset();
        test_add();
        test_sub();
        test_backpressure();
        test_accumulate();
        test_reset_mid();
        test_clear_race();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
